// File: rtl/bram_bank_seq_pkg.sv
// Shared definitions for the coefficient bank load/drain sequencer:
// FSM state encoding, default geometry and the address bit-reverse helper.
package bram_bank_seq_pkg;

   localparam int DEF_DATA_WIDTH = 54;
   localparam int DEF_ADDR_WIDTH = 10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   // Reverse the low 'width' bits of 'val'; bits above 'width' come back as zero.
   function automatic logic [31:0] bit_rev(input logic [31:0] val, input int width);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         if (i < width) begin
            r[i] = val[width - 1 - i];
         end
      end
      return r;
   endfunction

endpackage : bram_bank_seq_pkg

// File: rtl/bram_rd_skid.sv
// Two-entry skid that absorbs the one-cycle bank read latency on the drain
// side. It tracks the read in flight and tells the sequencer whether another
// read may be issued without overrunning the two entries.
module bram_rd_skid #(
   parameter int DATA_WIDTH = 54
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  rd_issue,
   input  logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  rd_allow
);

   logic                  inflight_q, inflight_d;
   logic [1:0]            cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
   logic [DATA_WIDTH-1:0] ent1_q, ent1_d;

   logic       pop;
   logic [1:0] kept;
   logic [2:0] occ;

   assign out_valid = (cnt_q != 2'd0);
   assign out_data  = ent0_q;
   assign pop       = out_valid & out_ready;

   // Occupancy seen by the next read: entries left after this cycle's pop
   // plus the read that lands this cycle. Counting the pop keeps one beat
   // per cycle flowing when the consumer never stalls.
   assign occ      = {1'b0, cnt_q} - {2'b00, pop} + {2'b00, inflight_q};
   assign rd_allow = (occ < 3'd2);

   // Next-state of the skid: pop shifts entry 1 forward, a landing read
   // fills the first free slot.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
      inflight_d = rd_issue;
      cnt_d      = cnt_q - {1'b0, pop} + {1'b0, inflight_q};
      ent0_d     = ent0_q;
      ent1_d     = ent1_q;
      kept       = cnt_q - {1'b0, pop};
      if (pop) begin
         ent0_d = ent1_q;
      end
      if (inflight_q) begin
         if (kept == 2'd0) begin
            ent0_d = rd_data;
         end else begin
            ent1_d = rd_data;
         end
      end
      if (flush) begin
         inflight_d = 1'b0;
         cnt_d      = 2'd0;
      end
   end

   // Skid state register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      if (!rst_n) begin
         inflight_q <= 1'b0;
         cnt_q      <= 2'd0;
         // NOTE: the two entries are plain flops, not RAM, so they are reset to give out_data a defined value.
         ent0_q     <= '0;
         ent1_q     <= '0;
      end else begin
         inflight_q <= inflight_d;
         cnt_q      <= cnt_d;
         ent0_q     <= ent0_d;
         ent1_q     <= ent1_d;
      end
   end

endmodule : bram_rd_skid

// File: rtl/bram_bank_seq.sv
// Load/drain sequencer for one coefficient bank: writes N coefficients in
// arrival order, then streams them back in natural or bit-reversed order
// through a latency-absorbing skid. The bank itself is external and is
// never cleared by reset.
module bram_bank_seq
   import bram_bank_seq_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  bitrev,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] bram_addr_read,
   output logic [ADDR_WIDTH-1:0] bram_addr_write,
   output logic                  bram_we,
   output logic [DATA_WIDTH-1:0] bram_data_in,
   input  logic [DATA_WIDTH-1:0] bram_data_out
);

   localparam logic [ADDR_WIDTH-1:0] LAST = '1;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
   logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
   logic [ADDR_WIDTH-1:0] out_cnt_q, out_cnt_d;
   logic                  rd_all_q, rd_all_d;
   logic                  bitrev_q, bitrev_d;

   logic                  frame_start;
   logic                  load_beat;
   logic                  drain_beat;
   logic                  last_beat;
   logic                  rd_issue;
   logic                  rd_allow;
   logic [ADDR_WIDTH-1:0] rd_addr;

   // start is only honoured in IDLE; a start during a frame, including the
   // cycle done pulses, falls through these terms unused.
   assign frame_start = (state_q == ST_IDLE) & start;
   assign load_beat   = (state_q == ST_LOAD) & in_valid;
   assign drain_beat  = (state_q == ST_DRAIN) & out_valid & out_ready;
   assign last_beat   = drain_beat & (out_cnt_q == LAST);
   // rd_all_q stops issue once the last address has gone out, so rd_cnt
   // never has to step past N-1.
   assign rd_issue    = (state_q == ST_DRAIN) & ~rd_all_q & rd_allow;
   assign rd_addr     = bitrev_q ? ADDR_WIDTH'(bit_rev(32'(rd_cnt_q), ADDR_WIDTH)) : rd_cnt_q;

   bram_rd_skid #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (frame_start),
      .rd_issue (rd_issue),
      .rd_data  (bram_data_out),
      .out_ready(out_ready),
      .out_valid(out_valid),
      .out_data (out_data),
      .rd_allow (rd_allow)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (frame_start) state_d = ST_LOAD;
         ST_LOAD:  if (load_beat && wr_cnt_q == LAST) state_d = ST_DRAIN;
         ST_DRAIN: if (last_beat) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // FSM outputs and the bank write/read ports.
   always_comb begin
      in_ready        = (state_q == ST_LOAD);
      busy            = (state_q != ST_IDLE);
      done            = last_beat;
      bram_we         = load_beat;
      bram_addr_write = wr_cnt_q;
      bram_data_in    = load_beat ? in_data : '0;
      bram_addr_read  = (state_q == ST_DRAIN) ? rd_addr : '0;
   end

   // Frame counters and latched drain order: cleared on frame start,
   // advanced by accepted writes, issued reads and transferred beats.
   always_comb begin
      wr_cnt_d  = wr_cnt_q;
      rd_cnt_d  = rd_cnt_q;
      out_cnt_d = out_cnt_q;
      rd_all_d  = rd_all_q;
      bitrev_d  = bitrev_q;
      if (frame_start) begin
         wr_cnt_d  = '0;
         rd_cnt_d  = '0;
         out_cnt_d = '0;
         rd_all_d  = 1'b0;
         bitrev_d  = bitrev;
      end
      if (load_beat) begin
         wr_cnt_d = wr_cnt_q + 1'b1;
      end
      if (rd_issue) begin
         if (rd_cnt_q == LAST) begin
            rd_all_d = 1'b1;
         end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
         end
      end
      if (drain_beat) begin
         out_cnt_d = out_cnt_q + 1'b1;
      end
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_cnt_q  <= '0;
         rd_cnt_q  <= '0;
         out_cnt_q <= '0;
         rd_all_q  <= 1'b0;
         bitrev_q  <= 1'b0;
      end else begin
         wr_cnt_q  <= wr_cnt_d;
         rd_cnt_q  <= rd_cnt_d;
         out_cnt_q <= out_cnt_d;
         rd_all_q  <= rd_all_d;
         bitrev_q  <= bitrev_d;
      end
   end

endmodule : bram_bank_seq

// File: tb/tb_bram_bank_seq.sv
// Directed bench for bram_bank_seq with an 8-entry bank model that returns
// read data one cycle after the address. Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge.
module tb_bram_bank_seq;

   localparam int DW = 16;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          bitrev;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          busy;
   logic          done;
   logic [AW-1:0] bram_addr_read;
   logic [AW-1:0] bram_addr_write;
   logic          bram_we;
   logic [DW-1:0] bram_data_in;
   logic [DW-1:0] bram_data_out;

   logic [DW-1:0] bank [8];
   int            rev_tab [8];
   int            vectors = 0;
   int            miscompares = 0;

   always #5 clk = ~clk;

   bram_bank_seq #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .bitrev         (bitrev),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .busy           (busy),
      .done           (done),
      .bram_addr_read (bram_addr_read),
      .bram_addr_write(bram_addr_write),
      .bram_we        (bram_we),
      .bram_data_in   (bram_data_in),
      .bram_data_out  (bram_data_out)
   );

   // Bank model: synchronous write, registered read (1-cycle latency).
   always @(posedge clk) begin
      if (bram_we) bank[bram_addr_write] <= bram_data_in;
      bram_data_out <= bank[bram_addr_read];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_we"}, 32'(bram_we), 32'd0);
      chk({tag, "_raddr"}, 32'(bram_addr_read), 32'd0);
      chk({tag, "_waddr"}, 32'(bram_addr_write), 32'd0);
      chk({tag, "_out_data"}, 32'(out_data), 32'd0);
      chk({tag, "_data_in"}, 32'(bram_data_in), 32'd0);
   endtask

   // Pulse start for one cycle while IDLE; bitrev is dropped afterwards so
   // the drain order depends on the latched copy.
   task automatic do_start(input logic br);
      start  = 1'b1;
      bitrev = br;
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      start  = 1'b0;
      bitrev = 1'b0;
   endtask

   // Load 0xA0+i to address i; optionally gap in_valid 1,0 and pulse start mid-load.
   task automatic do_load(input bit gapped, input bit pulse_start);
      int i = 0;
      int c = 0;
      while (i < 8 && c < 40) begin
         in_valid = gapped ? (c % 2 == 0) : 1'b1;
         in_data  = DW'(32'hA0 + i);
         start    = pulse_start && (c == 2);
         @(negedge clk);
         chk("load_in_ready", 32'(in_ready), 32'd1);
         chk("load_we", 32'(bram_we), 32'(in_valid));
         if (in_valid) begin
            chk("load_waddr", 32'(bram_addr_write), 32'(i));
            chk("load_wdata", 32'(bram_data_in), 32'(in_data));
            i++;
         end
         @(posedge clk); #1;
         c++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      chk("load_beats", 32'(i), 32'd8);
   endtask

   // Drain and check order, first-valid latency, stall stability and done.
   // abort_at < 8 applies reset after that many beats have transferred.
   task automatic do_drain(input bit use_rev, input bit stall_pat, input bit start_all, input int abort_at);
      int            k = 0;
      int            c = 0;
      int            first = -1;
      int            dones = 0;
      bit            prev_stall = 1'b0;
      logic [DW-1:0] prev_data = '0;
      logic [DW-1:0] exp_d;
      while (k < 8 && c < 80) begin
         if (k == abort_at) break;
         out_ready = stall_pat ? (c % 4 == 0 || c % 4 == 3) : 1'b1;
         start     = start_all;
         @(negedge clk);
         if (c == 0) chk("drain_in_ready", 32'(in_ready), 32'd0);
         chk("drain_busy", 32'(busy), 32'd1);
         if (out_valid && first < 0) first = c;
         if (!stall_pat && first >= 0) chk("drain_valid_run", 32'(out_valid), 32'd1);
         if (prev_stall) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'(prev_data));
         end
         exp_d = DW'(32'hA0 + (use_rev ? rev_tab[k] : k));
         if (out_valid && out_ready) begin
            chk("drain_data", 32'(out_data), 32'(exp_d));
            chk("drain_done", 32'(done), 32'(k == 7));
            k++;
         end else begin
            chk("drain_idle_done", 32'(done), 32'd0);
         end
         if (done) dones++;
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         if (k == 8) break;
         @(posedge clk); #1;
         c++;
      end
      chk("first_valid", 32'(first), 32'd2);
      if (abort_at < 8) begin
         chk("abort_beats", 32'(k), 32'(abort_at));
         rst_n     = 1'b0;
         out_ready = 1'b0;
         start     = 1'b0;
         @(posedge clk); #1;
         @(negedge clk);
         chk_reset_vals("abort");
         @(posedge clk); #1;
         rst_n = 1'b1;
      end else begin
         chk("drain_beats", 32'(k), 32'd8);
         chk("done_count", 32'(dones), 32'd1);
         @(posedge clk); #1;
         start     = 1'b0;
         out_ready = 1'b0;
         @(negedge clk);
         chk("end_busy", 32'(busy), 32'd0);
         chk("end_out_valid", 32'(out_valid), 32'd0);
         chk("end_done", 32'(done), 32'd0);
         @(posedge clk); #1;
         @(negedge clk);
         chk("no_restart_busy", 32'(busy), 32'd0);
         chk("no_restart_in_ready", 32'(in_ready), 32'd0);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "simulation did not finish");
   end

   initial begin
      rev_tab   = '{0, 4, 2, 6, 1, 5, 3, 7};
      rst_n     = 1'b0;
      start     = 1'b0;
      bitrev    = 1'b0;
      in_valid  = 1'b0;
      in_data   = 16'h5A5A;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk_reset_vals("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Natural order, continuous load and drain.
      do_start(1'b0);
      do_load(1'b0, 1'b0);
      do_drain(1'b0, 1'b0, 1'b0, 99);

      // Bit-reversed drain.
      do_start(1'b1);
      do_load(1'b0, 1'b0);
      do_drain(1'b1, 1'b0, 1'b0, 99);

      // Consumer stalls with out_ready 1,0,0,1.
      do_start(1'b0);
      do_load(1'b0, 1'b0);
      do_drain(1'b0, 1'b1, 1'b0, 99);

      // Reset after three drain beats, then a full frame.
      do_start(1'b0);
      do_load(1'b0, 1'b0);
      do_drain(1'b0, 1'b0, 1'b0, 3);
      do_start(1'b0);
      do_load(1'b0, 1'b0);
      do_drain(1'b0, 1'b0, 1'b0, 99);

      // start pulsed mid-load and held through the drain, including the done cycle.
      do_start(1'b0);
      do_load(1'b0, 1'b1);
      do_drain(1'b0, 1'b0, 1'b1, 99);

      // Gapped load.
      do_start(1'b0);
      do_load(1'b1, 1'b0);
      do_drain(1'b0, 1'b0, 1'b0, 99);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_bram_bank_seq
